// File: rtl/perf_monitor.sv
// Performance monitor: per-channel saturating event counters plus a RUN-cycle counter with an optional limit.
// Optional shadow snapshot bank is enabled by defining PERF_MONITOR_SNAPSHOT_EN.
module perf_monitor #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    localparam int SEL_W  = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clr_i,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [NUM_EVT-1:0] ovf_o,
    output logic               done_o
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic               count_en;
    logic [CNT_W-1:0]   cyc;
    logic [CNT_W-1:0]   cyc_nxt;
    logic [CNT_W:0]     cyc_inc;
    logic [CNT_W-1:0]   cnt     [NUM_EVT];
    logic [CNT_W-1:0]   cnt_nxt [NUM_EVT];
    logic [NUM_EVT-1:0] ovf;
    logic [NUM_EVT-1:0] ovf_nxt;

    // One extra bit so a saturated cycle counter can never alias onto the limit.
    assign cyc_inc = {1'b0, cyc} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = RUN;
            end
            RUN: begin
                if (!start_i) begin
                    state_nxt = HOLD;
                end else begin
                    count_en = 1'b1;
                    if ((limit_i != '0) && (cyc_inc == {1'b0, limit_i})) state_nxt = DONE;
                end
            end
            HOLD: begin
                if (start_i) state_nxt = RUN;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cyc_nxt = cyc;
        ovf_nxt = ovf;
        if (count_en && (cyc != CNT_MAX)) cyc_nxt = cyc + CNT_W'(1);
        for (int i = 0; i < NUM_EVT; i++) begin
            cnt_nxt[i] = cnt[i];
            if (count_en && event_i[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    ovf_nxt[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cyc <= '0;
            ovf <= '0;
            for (int i = 0; i < NUM_EVT; i++) cnt[i] <= '0;
        end else begin
            cyc <= cyc_nxt;
            ovf <= ovf_nxt;
            for (int i = 0; i < NUM_EVT; i++) cnt[i] <= cnt_nxt[i];
        end
    end

`ifdef PERF_MONITOR_SNAPSHOT_EN
    logic [CNT_W-1:0] shd_cyc;
    logic [CNT_W-1:0] shd_cnt [NUM_EVT];

    // Snapshot captures the post-edge values so a snap taken while counting includes that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            shd_cyc <= '0;
            for (int i = 0; i < NUM_EVT; i++) shd_cnt[i] <= '0;
        end else if (snap_i) begin
            shd_cyc <= cyc_nxt;
            for (int i = 0; i < NUM_EVT; i++) shd_cnt[i] <= cnt_nxt[i];
        end
    end

    assign cycle_o = shd_cyc;

    always_comb begin
        rd_data_o = '0;
        if (int'(rd_sel_i) < NUM_EVT) rd_data_o = shd_cnt[rd_sel_i];
    end
`else
    logic unused_snap;
    assign unused_snap = snap_i;
    assign cycle_o     = cyc;

    always_comb begin
        rd_data_o = '0;
        if (int'(rd_sel_i) < NUM_EVT) rd_data_o = cnt[rd_sel_i];
    end
`endif

    assign ovf_o  = ovf;
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: directed scenarios plus randomized traffic against a reference model.
// Two instances: a wide one (4 channels, 32-bit) and a narrow one (3 channels, 4-bit) for saturation and select range.
module tb_perf_monitor;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        start;
    logic [3:0]  ev;
    logic [31:0] limit;
    logic [3:0]  lim_s;
    logic        snap;
    logic [1:0]  sel;
    logic [1:0]  sel_s;

    logic [31:0] rd_b;
    logic [31:0] cyc_b;
    logic [3:0]  ovf_b;
    logic        done_b;
    logic [3:0]  rd_s;
    logic [3:0]  cyc_s;
    logic [2:0]  ovf_s;
    logic        done_s;

    int n_chk = 0;
    int n_err = 0;

    // reference state, index 0 = wide instance, 1 = narrow instance
    longint m_cnt    [2][4];
    longint m_cyc    [2];
    bit     m_ovf    [2][4];
    int     m_mode   [2];
    longint m_sh_cnt [2][4];
    longint m_sh_cyc [2];

    perf_monitor #(.NUM_EVT(4), .CNT_W(32)) u_big (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr),
        .event_i(ev), .limit_i(limit), .snap_i(snap), .rd_sel_i(sel),
        .rd_data_o(rd_b), .cycle_o(cyc_b), .ovf_o(ovf_b), .done_o(done_b)
    );

    perf_monitor #(.NUM_EVT(3), .CNT_W(4)) u_sml (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr),
        .event_i(ev[2:0]), .limit_i(lim_s), .snap_i(snap), .rd_sel_i(sel_s),
        .rd_data_o(rd_s), .cycle_o(cyc_s), .ovf_o(ovf_s), .done_o(done_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input longint lim);
        longint mx;
        int     n;
        mx = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
        n  = (k == 0) ? 4 : 3;
        if (rst || clr) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[k][i] = 0; m_ovf[k][i] = 0; m_sh_cnt[k][i] = 0;
            end
            m_cyc[k] = 0; m_sh_cyc[k] = 0; m_mode[k] = M_IDLE;
            return;
        end
        case (m_mode[k])
            M_IDLE: if (start) m_mode[k] = M_RUN;
            M_HOLD: if (start) m_mode[k] = M_RUN;
            M_RUN: begin
                if (!start) begin
                    m_mode[k] = M_HOLD;
                end else begin
                    if (lim != 0 && m_cyc[k] + 1 == lim) m_mode[k] = M_DONE;
                    if (m_cyc[k] < mx) m_cyc[k] = m_cyc[k] + 1;
                    for (int i = 0; i < n; i++) begin
                        if (ev[i]) begin
                            if (m_cnt[k][i] == mx) m_ovf[k][i] = 1;
                            else m_cnt[k][i] = m_cnt[k][i] + 1;
                        end
                    end
                end
            end
            default: ;
        endcase
`ifdef PERF_MONITOR_SNAPSHOT_EN
        if (snap) begin
            m_sh_cyc[k] = m_cyc[k];
            for (int i = 0; i < 4; i++) m_sh_cnt[k][i] = m_cnt[k][i];
        end
`endif
    endtask

    function automatic longint exp_rd(input int k, input int s);
        int n;
        n = (k == 0) ? 4 : 3;
        if (s >= n) return 0;
`ifdef PERF_MONITOR_SNAPSHOT_EN
        return m_sh_cnt[k][s];
`else
        return m_cnt[k][s];
`endif
    endfunction

    function automatic longint exp_cyc(input int k);
`ifdef PERF_MONITOR_SNAPSHOT_EN
        return m_sh_cyc[k];
`else
        return m_cyc[k];
`endif
    endfunction

    function automatic logic [3:0] exp_ovf(input int k);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = m_ovf[k][i];
        if (k == 1) v[3] = 1'b0;
        return v;
    endfunction

    task automatic compare_all();
        check("cyc_b",  64'(cyc_b),  64'(exp_cyc(0)));
        check("rd_b",   64'(rd_b),   64'(exp_rd(0, int'(sel))));
        check("ovf_b",  64'(ovf_b),  64'(exp_ovf(0)));
        check("done_b", 64'(done_b), 64'(m_mode[0] == M_DONE));
        check("cyc_s",  64'(cyc_s),  64'(exp_cyc(1)));
        check("rd_s",   64'(rd_s),   64'(exp_rd(1, int'(sel_s))));
        check("ovf_s",  64'(ovf_s),  64'(exp_ovf(1)));
        check("done_s", 64'(done_s), 64'(m_mode[1] == M_DONE));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, longint'(limit));
        model_step(1, longint'(lim_s));
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; start = 1'b0; ev = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b0; ev = '0; limit = '0; lim_s = '0;
        snap = 1'b0; sel = '0; sel_s = '0;

        // reset state, with out-of-range select on the narrow instance
        sel_s = 2'd3;
        do_reset();
        check("rst_cyc",  64'(cyc_b), 64'd0);
        check("rst_done", 64'(done_b), 64'd0);
        check("rst_rd_s", 64'(rd_s), 64'd0);

        // snap held high in directed runs so shadow readback equals live counts in either build
        snap = 1'b1;

        // limit 64, event 0 on every third RUN cycle
        limit = 32'd64; start = 1'b1; sel = 2'd0;
        step();
        for (int r = 1; r <= 64; r++) begin
            ev = ((r - 1) % 3 == 0) ? 4'b0001 : 4'b0000;
            step();
        end
        check("lim_done", 64'(done_b), 64'd1);
        check("lim_cyc",  64'(cyc_b), 64'd64);
        check("lim_ch0",  64'(rd_b), 64'd22);
        ev = 4'b1111;
        for (int r = 0; r < 5; r++) step();
        check("done_frozen_cyc", 64'(cyc_b), 64'd64);
        check("done_frozen_ch0", 64'(rd_b), 64'd22);

        // pause and resume
        limit = '0; do_reset();
        start = 1'b1; ev = 4'b0010; sel = 2'd1;
        step();
        for (int r = 0; r < 10; r++) step();
        start = 1'b0;
        for (int r = 0; r < 5; r++) step();
        check("hold_cyc", 64'(cyc_b), 64'd10);
        start = 1'b1;
        for (int r = 0; r < 11; r++) step();
        check("resume_cyc", 64'(cyc_b), 64'd20);
        check("resume_ch1", 64'(rd_b), 64'd20);

        // saturation on the narrow instance
        do_reset();
        start = 1'b1; ev = 4'b0100; sel_s = 2'd2; sel = 2'd2;
        step();
        for (int r = 0; r < 20; r++) step();
        check("sat_ch2",  64'(rd_s), 64'd15);
        check("sat_ovf",  64'(ovf_s), 64'b100);
        check("sat_cyc",  64'(cyc_s), 64'd15);
        check("wide_ch2", 64'(rd_b), 64'd20);
        check("wide_ovf", 64'(ovf_b), 64'd0);

        // clear beats a same-cycle event
        do_reset();
        start = 1'b1; ev = 4'b1000; sel = 2'd3;
        step();
        for (int r = 0; r < 7; r++) step();
        check("pre_clr_ch3", 64'(rd_b), 64'd7);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ch3",  64'(rd_b), 64'd0);
        check("clr_done", 64'(done_b), 64'd0);
        step();
        check("clr_idle_cyc", 64'(cyc_b), 64'd0);
        step();
        check("clr_run_cyc", 64'(cyc_b), 64'd1);

`ifdef PERF_MONITOR_SNAPSHOT_EN
        // snapshot taken on the edge where the live count goes 9 -> 10
        do_reset();
        snap = 1'b0; limit = 32'd30; start = 1'b1; ev = 4'b0001; sel = 2'd0;
        step();
        for (int r = 1; r <= 30; r++) begin
            snap = (r == 10);
            step();
        end
        snap = 1'b0;
        check("snap_cyc",  64'(cyc_b), 64'd10);
        check("snap_ch0",  64'(rd_b), 64'd10);
        check("snap_done", 64'(done_b), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("done_rst_cyc",  64'(cyc_b), 64'd0);
        check("done_rst_rd",   64'(rd_b), 64'd0);
        check("done_rst_done", 64'(done_b), 64'd0);
`endif

        // randomized traffic
        do_reset();
        limit = 32'd0; lim_s = 4'd0;
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            clr   = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 9) < 8);
            ev    = 4'($urandom);
            snap  = ($urandom_range(0, 7) == 0);
            sel   = 2'($urandom);
            sel_s = 2'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 2))
                    0: limit = 32'd0;
                    1: limit = 32'($urandom_range(1, 120));
                    default: limit = 32'(m_cyc[0] + longint'($urandom_range(0, 20)) - 10);
                endcase
            end
            if ($urandom_range(0, 39) == 0) lim_s = 4'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
